// File: rtl/systolic_feeder.sv
// Systolic array operand feeder.
// Collects four A/B row beats into a tile buffer, then streams the tile to
// a 4x4 systolic array with a one-cycle-per-lane diagonal skew, followed by
// FLUSH idle cycles so the array drains before tile_done pulses.
// Optional feature: define FEEDER_DOUBLE_BUFFER_EN for two ping-pong tile
// buffers, so the next tile loads while the current one is being emitted.
// When it is undefined there is a single buffer, and input stalls from the
// 4th beat until tile_done.
module systolic_feeder #(
    parameter int DATA_W = 16,
    parameter int FLUSH  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DATA_W-1:0] in_a,
    input  logic [4*DATA_W-1:0] in_b,
    output logic [4*DATA_W-1:0] a,
    output logic [4*DATA_W-1:0] b,
    output logic                busy,
    output logic                tile_done
);

    localparam int LW   = 4 * DATA_W;            // one row of four lanes
    localparam int TW   = 4 * LW;                // one tile of four rows
    localparam int CMAX = (FLUSH > 7) ? FLUSH : 7;
    localparam int CW   = $clog2(CMAX);
`ifdef FEEDER_DOUBLE_BUFFER_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ecnt_q, ecnt_d;
    logic [1:0]      lcnt_q, lcnt_d;
    logic            wr_sel_q, wr_sel_d;
    logic            rd_sel_q, rd_sel_d;
    logic [NBUF-1:0] full_q, full_d;
    logic [NBUF-1:0] avail;
    logic [LW-1:0]   a_q, a_d;
    logic [LW-1:0]   b_q, b_d;
    logic [TW-1:0]   ta_q [NBUF];
    logic [TW-1:0]   tb_q [NBUF];
    logic            xfer;
    logic            wrap;

    // Lane i during emit cycle c carries row (c-i) of the tile, zero outside the diagonal band.
    function automatic logic [LW-1:0] skew(input logic [TW-1:0] rows, input logic [CW-1:0] c);
        logic [LW-1:0] r;
        int            s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = int'(c) - i;
            if (s >= 0 && s <= 3) begin
                r[i*DATA_W +: DATA_W] = rows[(s*4+i)*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    // in_ready comes only from registered buffer state.
    assign in_ready  = !full_q[wr_sel_q];
    assign xfer      = in_valid && in_ready;
    assign wrap      = xfer && (lcnt_q == 2'd3);
    assign busy      = (state_q != S_IDLE);
    assign tile_done = (state_q == S_FLUSH) && (ecnt_q == CW'(FLUSH - 1));
    assign a         = a_q;
    assign b         = b_q;

    // A buffer is ready for emission if already full or being completed by this cycle's beat.
    always_comb begin
        avail = full_q;
        if (wrap) begin
            avail[wr_sel_q] = 1'b1;
        end
    end

    // Load side: beat counter, buffer fill flags, release on tile_done.
    always_comb begin
        lcnt_d   = lcnt_q;
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        if (tile_done) begin
            full_d[rd_sel_q] = 1'b0;
        end
        if (xfer) begin
            lcnt_d = lcnt_q + 2'd1;
        end
        if (wrap) begin
            full_d[wr_sel_q] = 1'b1;
`ifdef FEEDER_DOUBLE_BUFFER_EN
            wr_sel_d = ~wr_sel_q;
`endif
        end
    end

    // Emitter FSM: IDLE -> EMIT (7 cycles) -> FLUSH (FLUSH cycles) -> IDLE or next EMIT.
    always_comb begin
        state_d  = state_q;
        ecnt_d   = ecnt_q;
        rd_sel_d = rd_sel_q;
        case (state_q)
            S_IDLE: begin
                if (avail[rd_sel_q]) begin
                    state_d = S_EMIT;
                    ecnt_d  = '0;
                end
            end
            S_EMIT: begin
                if (ecnt_q == CW'(6)) begin
                    state_d = S_FLUSH;
                    ecnt_d  = '0;
                end else begin
                    ecnt_d = ecnt_q + CW'(1);
                end
            end
            S_FLUSH: begin
                if (tile_done) begin
                    ecnt_d  = '0;
                    state_d = S_IDLE;
`ifdef FEEDER_DOUBLE_BUFFER_EN
                    rd_sel_d = ~rd_sel_q;
                    if (avail[~rd_sel_q]) begin
                        state_d = S_EMIT;
                    end
`endif
                end else begin
                    ecnt_d = ecnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                ecnt_d  = '0;
            end
        endcase
    end

    // Registered outputs are computed from the next state so they line up with the emit cycle.
    always_comb begin
        a_d = '0;
        b_d = '0;
        if (state_d == S_EMIT) begin
            a_d = skew(ta_q[rd_sel_d], ecnt_d);
            b_d = skew(tb_q[rd_sel_d], ecnt_d);
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ecnt_q   <= '0;
            lcnt_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            full_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            ecnt_q   <= ecnt_d;
            lcnt_q   <= lcnt_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            full_q   <= full_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    // Tile storage; validity is tracked by full_q, so the data needs no reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            ta_q[wr_sel_q][int'(lcnt_q)*LW +: LW] <= in_a;
            tb_q[wr_sel_q][int'(lcnt_q)*LW +: LW] <= in_b;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (either buffer configuration).
module tb_systolic_feeder;

    localparam int DATA_W = 16;
    localparam int FLUSH  = 5;
`ifdef FEEDER_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [4*DATA_W-1:0] in_a;
    logic [4*DATA_W-1:0] in_b;
    logic [4*DATA_W-1:0] a;
    logic [4*DATA_W-1:0] b;
    logic                busy;
    logic                tile_done;

    int tests  = 0;
    int failed = 0;

    systolic_feeder #(.DATA_W(DATA_W), .FLUSH(FLUSH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .tile_done(tile_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Row s of a tile whose element [s][i] is base + stride*(4s+i).
    function automatic logic [63:0] row(input logic [15:0] base, input int stride, input int s);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(int'(base) + stride * (4*s + i));
        return r;
    endfunction

    // Expected skewed vector during emit cycle c.
    function automatic logic [63:0] exp_vec(input logic [15:0] base, input int stride, input int c);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (c - i >= 0 && c - i <= 3) r[i*16 +: 16] = 16'(int'(base) + stride * (4*(c - i) + i));
        end
        return r;
    endfunction

    // Load four beats; gaps[s] idle cycles precede beat s. Returns in cycle after 4th transfer.
    task automatic load_tile(input logic [15:0] ba, input int sa, input logic [15:0] bb, input int sb,
                             input int g0, input int g1, input int g2, input int g3);
        int gaps [4];
        int w;
        gaps = '{g0, g1, g2, g3};
        for (int s = 0; s < 4; s++) begin
            in_valid = 1'b0;
            for (int g = 0; g < gaps[s]; g++) step();
            in_valid = 1'b1;
            in_a = row(ba, sa, s);
            in_b = row(bb, sb, s);
            w = 0;
            while (!in_ready && w < 50) begin
                step();
                w++;
            end
            if (w >= 50) begin
                tests++;
                failed++;
                $error("FAIL ready_wait observed=0 expected=1");
            end
            step();
        end
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
    endtask

    logic [63:0] obs_a [7];

    // Called in cycle E0; checks every emit and flush cycle, returns in the cycle after tile_done.
    task automatic check_tile(input logic [15:0] ba, input int sa, input logic [15:0] bb, input int sb);
        for (int c = 0; c < 7; c++) begin
            obs_a[c] = a;
            chk("emit_a", a, exp_vec(ba, sa, c));
            chk("emit_b", b, exp_vec(bb, sb, c));
            chk("emit_busy", 64'(busy), 64'd1);
            chk("emit_done", 64'(tile_done), 64'd0);
            chk("emit_ready", 64'(in_ready), 64'(DB));
            step();
        end
        for (int f = 0; f < FLUSH; f++) begin
            chk("flush_a", a, 64'd0);
            chk("flush_b", b, 64'd0);
            chk("flush_busy", 64'(busy), 64'd1);
            chk("flush_done", 64'(tile_done), 64'(f == FLUSH - 1));
            chk("flush_ready", 64'(in_ready), 64'(DB));
            step();
        end
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_ready", 64'(in_ready), 64'd1);
        chk("post_a", a, 64'd0);
    endtask

    logic [63:0] rec_a   [60];
    logic        rec_rdy [60];
    logic        rec_done[60];
    int          xcyc    [8];
    int          td_at   [2];

    initial begin
        int beat;
        int t3;
        int e1;
        int zeros;
        int ntd;

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        step();
        step();
        chk("rst_a", a, 64'd0);
        chk("rst_b", b, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(tile_done), 64'd0);
        rst = 1'b0;
        step();
        chk("rst_ready", 64'(in_ready), 64'd1);

        // Single tile, A ramp, B constant 3F80.
        load_tile(16'h3F80, 1, 16'h3F80, 0, 0, 0, 0, 0);
        check_tile(16'h3F80, 1, 16'h3F80, 0);
        chk("e0p3_a", obs_a[3], 64'h3F83_3F86_3F89_3F8C);
        chk("e0p6_a", obs_a[6], 64'h3F8F_0000_0000_0000);

        // Gapped beats (valid pattern 1,0,0,1,1,0,1) give the same skewed stream.
        load_tile(16'h4000, 1, 16'h1000, 3, 0, 2, 0, 1);
        check_tile(16'h4000, 1, 16'h1000, 3);

        // Two tiles with in_valid held high.
        beat = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            rec_a[cyc] = a;
            rec_rdy[cyc] = in_ready;
            rec_done[cyc] = tile_done;
            if (beat < 8) begin
                in_valid = 1'b1;
                in_a = row((beat < 4) ? 16'h1100 : 16'h2200, 1, beat % 4);
                in_b = row((beat < 4) ? 16'h3300 : 16'h4400, 1, beat % 4);
                if (in_ready) begin
                    xcyc[beat] = cyc;
                    beat++;
                end
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        chk("b2b_beats", 64'(beat), 64'd8);
        ntd = 0;
        td_at = '{-1, -1};
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (rec_done[cyc]) begin
                if (ntd < 2) td_at[ntd] = cyc;
                ntd++;
            end
        end
        chk("b2b_ndone", 64'(ntd), 64'd2);
        t3 = xcyc[3];
        chk("b2b_td0", 64'(td_at[0]), 64'(t3 + 12));
        if (DB) begin
            zeros = 0;
            for (int cyc = 0; cyc <= xcyc[7]; cyc++) if (!rec_rdy[cyc]) zeros++;
            chk("db_ready_drops", 64'(zeros), 64'd0);
            chk("db_beat7", 64'(xcyc[7]), 64'(xcyc[0] + 7));
            e1 = td_at[0] + 1;
        end else begin
            zeros = 0;
            for (int cyc = t3 + 1; cyc <= t3 + 12; cyc++) if (!rec_rdy[cyc]) zeros++;
            chk("sb_ready_low", 64'(zeros), 64'd12);
            chk("sb_ready_back", 64'(rec_rdy[t3 + 13]), 64'd1);
            chk("sb_beat4", 64'(xcyc[4]), 64'(td_at[0] + 1));
            e1 = xcyc[7] + 1;
        end
        chk("t1_pre_e0", rec_a[e1 - 1], 64'd0);
        chk("t1_e0", rec_a[e1], 64'h0000_0000_0000_2200);
        chk("t1_e0p3", rec_a[e1 + 3], 64'h2203_2206_2209_220C);
        chk("b2b_td1", 64'(td_at[1]), 64'(e1 + 11));

        // Reset in cycle E0+2 of a tile.
        load_tile(16'h5000, 1, 16'h6000, 1, 0, 0, 0, 0);
        step();
        step();
        chk("pre_rst_a", a, exp_vec(16'h5000, 1, 2));
        rst = 1'b1;
        step();
        chk("mid_rst_a", a, 64'd0);
        chk("mid_rst_b", b, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        step();
        chk("after_rst_ready", 64'(in_ready), 64'd1);
        ntd = 0;
        zeros = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (tile_done) ntd++;
            if (a != 64'd0 || b != 64'd0) zeros++;
            step();
        end
        chk("rst_no_done", 64'(ntd), 64'd0);
        chk("rst_quiet_ab", 64'(zeros), 64'd0);

        // Reset mid-load discards the partial tile; the next tile starts at beat 0.
        in_valid = 1'b1;
        in_a = row(16'h7700, 1, 0);
        in_b = row(16'h7700, 1, 0);
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        load_tile(16'h0A00, 2, 16'h0B00, 1, 0, 0, 0, 0);
        check_tile(16'h0A00, 2, 16'h0B00, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
Parameters:
- REQ-001: DATA_W, 16, operand width in bits (bfloat16); fixed at 16 for compatibility with the 4x4 systolic array.
- REQ-002: FLUSH, 5, number of idle cycles after the last skewed operand so the array can drain before tile_done.

Ports:
- REQ-003: clk  input  1  single clock; all logic is rising-edge.
- REQ-004: rst  input  1  synchronous reset, active-high.
- REQ-005: in_valid  input  1  upstream beat valid.
- REQ-006: in_ready  output  1  feeder can accept a beat.
- REQ-007: in_a  input  4*DATA_W  step-s row of tile A; lane i is bits [16*i+15:16*i].
- REQ-008: in_b  input  4*DATA_W  step-s row of tile B; same lane packing.
- REQ-009: a  output  4*DATA_W  skewed A lanes to the array's a port; registered.
- REQ-010: b  output  4*DATA_W  skewed B lanes to the array's b port; registered.
- REQ-011: busy  output  1  emitter not IDLE.
- REQ-012: tile_done  output  1  one-cycle pulse; the tile's products are fully accumulated in the array.

Function
- REQ-013: A beat transfers on a cycle with in_valid && in_ready; four beats (steps s=0..3) form one tile, written as TA[s][i]=in_a lane i and TB[s][i]=in_b lane i.
- REQ-014: A 2-bit load counter advances per transfer and wraps 3->0; a wrap marks the load buffer full.
- REQ-015: The emitter FSM has three states: IDLE, EMIT (7 cycles), and FLUSH (FLUSH cycles).
- REQ-016: IDLE->EMIT occurs when a full buffer exists; EMIT->FLUSH occurs after emit count 6; FLUSH->IDLE, or FLUSH->EMIT if another full buffer is waiting, occurs after FLUSH count FLUSH-1.
- REQ-017: Let E0 be the first EMIT cycle; when the emitter is IDLE, E0 is the cycle after the 4th-beat transfer.
- REQ-018: During emit cycle c (0..6), lane i of a SHALL equal TA[c-i][i] if 0<=c-i<=3, else 0; the same rule applies to b with TB.
- REQ-019: a and b SHALL be all-zero in IDLE and FLUSH.
- REQ-020: tile_done SHALL be high only in the last FLUSH cycle, cycle E0+6+FLUSH; busy is high from E0 through that cycle.
- REQ-021: Tiles are emitted strictly in load order; the next tile's E0 is no earlier than the cycle after the previous tile_done.
- REQ-022: A buffer is released in the cycle tile_done is high.
- REQ-023: in_ready depends only on registered state, never on in_valid.
- REQ-024: When a beat completes a tile in the same cycle that tile_done releases a buffer, both events take effect; no beat is lost or duplicated.
- REQ-025: Beats with in_valid low never advance the load counter; gaps between beats within a tile are allowed.

Reset
- REQ-026: While rst is high at a clock edge: state -> IDLE, counters -> 0, all buffers -> empty, a=0, b=0, busy=0, tile_done=0.
- REQ-027: in_ready SHALL be 1 in the cycle after rst deasserts.
- REQ-028: Reset mid-load or mid-emit discards all tile data; no tile_done is produced for a discarded tile.

Configuration
- REQ-029: Macro FEEDER_DOUBLE_BUFFER_EN defined: two ping-pong tile buffers; in_ready=1 whenever the current load buffer is not full, so the next tile loads during EMIT/FLUSH.
- REQ-030: Macro FEEDER_DOUBLE_BUFFER_EN undefined: one tile buffer; in_ready=0 from the 4th-beat transfer through the tile_done cycle, then 1.

Verification
- REQ-031: Reset then single tile, TA[s][i]=16'h3F80+4s+i, TB all 16'h3F80, FLUSH=5 -> at E0+3, a = {TA[0][3],TA[1][2],TA[2][1],TA[3][0]}; at E0+6, only lane 3 is nonzero (TA[3][3]); tile_done at E0+11 only.
- REQ-032: Two tiles back-to-back with in_valid held high, double buffer on -> in_ready never drops for the 8 beats; second tile E0 = first tile_done cycle + 1.
- REQ-033: Same stimulus as REQ-032 with double buffer off -> in_ready=0 for 12 cycles after the 4th beat; the second tile loads only after tile_done.
- REQ-034: Beats with random in_valid gaps (e.g. pattern 1,0,0,1,1,0,1) -> tile content and skew are identical to the gap-free case.
- REQ-035: rst pulsed at E0+2 -> a=b=0 from the next cycle, no tile_done, and in_ready=1 the cycle after rst falls.
- REQ-036: End-to-end with the systolic array: A, B = identity -> array results equal the expected bf16 identity product after tile_done.
